// File: rtl/code_lock_param.sv
// ----------------------------------------------------------------------------
// code_lock_param
// Two-button digital code lock. Digits are entered serially (MSB first) and
// compared against a programmable code register once CODE_LEN digits have
// been collected. A match opens the lock for UNLOCK_CYC cycles. MAX_FAIL
// consecutive mismatches trigger an alarm lockout of LOCKOUT_CYC cycles.
// While unlocked, the code register can be reprogrammed.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   b0, b1     digit buttons: 10 -> digit 0, 01 -> digit 1, 11 -> clear
//   prog_en    load prog_code into the code register (UNLOCK state only)
//   prog_code  new code, MSB = first digit entered
//   unlock     registered, high while in UNLOCK
//   alarm      registered, high while in LOCKOUT
//   fail_cnt   registered count of consecutive failed attempts
//   digit_cnt  registered count of digits entered in the current attempt
// ----------------------------------------------------------------------------
module code_lock_param #(
   parameter int unsigned          CODE_LEN     = 5,
   parameter logic [CODE_LEN-1:0]  DEFAULT_CODE = 5'b01011,
   parameter int unsigned          MAX_FAIL     = 3,
   parameter int unsigned          UNLOCK_CYC   = 4,
   parameter int unsigned          LOCKOUT_CYC  = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              b0,
   input  logic                              b1,
   input  logic                              prog_en,
   input  logic [CODE_LEN-1:0]               prog_code,
   output logic                              unlock,
   output logic                              alarm,
   output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
   output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt
);

   localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
   localparam int unsigned DW   = $clog2(CODE_LEN + 1);
   localparam int unsigned TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_UNLOCK  = 2'd1,
      ST_LOCKOUT = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   // Only the first CODE_LEN-1 digits need storing; the last one is
   // compared straight from the buttons in the cycle it is accepted.
   logic [CODE_LEN-2:0]   r_entry;
   logic [CODE_LEN-1:0]   r_code;
   logic [DW-1:0]         r_digit_cnt;
   logic [FW-1:0]         r_fail_cnt;
   logic [TW-1:0]         r_timer;
   logic                  r_unlock;
   logic                  r_alarm;

   logic [CODE_LEN-2:0]   w_entry_nxt;
   logic [CODE_LEN-1:0]   w_code_nxt;
   logic [DW-1:0]         w_digit_nxt;
   logic [FW-1:0]         w_fail_nxt;
   logic [TW-1:0]         w_timer_nxt;
   logic                  w_unlock_nxt;
   logic                  w_alarm_nxt;

   logic                  w_digit;
   logic                  w_clear;
   logic                  w_last;
   logic [CODE_LEN-1:0]   w_entry_shift;
   logic                  w_match;

   // Button decode: exactly one pressed is a digit (value = b1), both is clear
   assign w_digit       = b0 ^ b1;
   assign w_clear       = b0 & b1;
   assign w_last        = (r_digit_cnt == DW'(CODE_LEN - 1));
   assign w_entry_shift = {r_entry, b1};
   assign w_match       = (w_entry_shift == r_code);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_ENTRY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath next values
   always_comb begin
      w_state_nxt = r_state;
      w_entry_nxt = r_entry;
      w_code_nxt  = r_code;
      w_digit_nxt = r_digit_cnt;
      w_fail_nxt  = r_fail_cnt;
      w_timer_nxt = r_timer;

      case (r_state)
         ST_ENTRY: begin
            if (w_clear) begin
               w_entry_nxt = '0;
               w_digit_nxt = '0;
            end else if (w_digit) begin
               if (w_last) begin
                  w_entry_nxt = '0;
                  w_digit_nxt = '0;
                  if (w_match) begin
                     w_state_nxt = ST_UNLOCK;
                     w_fail_nxt  = '0;
                     w_timer_nxt = TW'(UNLOCK_CYC - 1);
                  end else if (r_fail_cnt == FW'(MAX_FAIL - 1)) begin
                     w_state_nxt = ST_LOCKOUT;
                     w_fail_nxt  = FW'(MAX_FAIL);
                     w_timer_nxt = TW'(LOCKOUT_CYC - 1);
                  end else begin
                     w_fail_nxt  = r_fail_cnt + FW'(1);
                  end
               end else begin
                  w_entry_nxt = w_entry_shift[CODE_LEN-2:0];
                  w_digit_nxt = r_digit_cnt + DW'(1);
               end
            end
         end

         ST_UNLOCK: begin
            w_entry_nxt = '0;
            w_digit_nxt = '0;
            if (prog_en) begin
               w_code_nxt = prog_code;
            end
            // Timer is loaded with UNLOCK_CYC-1 so the state lasts UNLOCK_CYC cycles
            if (r_timer == '0) begin
               w_state_nxt = ST_ENTRY;
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end

         ST_LOCKOUT: begin
            w_entry_nxt = '0;
            w_digit_nxt = '0;
            if (r_timer == '0) begin
               w_state_nxt = ST_ENTRY;
               w_fail_nxt  = '0;
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end

         default: begin
            w_state_nxt = ST_ENTRY;
            w_entry_nxt = '0;
            w_digit_nxt = '0;
            w_fail_nxt  = '0;
            w_timer_nxt = '0;
         end
      endcase
   end

   // Output decode from the next state so the flags register in step with it
   always_comb begin
      w_unlock_nxt = 1'b0;
      w_alarm_nxt  = 1'b0;
      case (w_state_nxt)
         ST_UNLOCK:  w_unlock_nxt = 1'b1;
         ST_LOCKOUT: w_alarm_nxt  = 1'b1;
         default: begin
            w_unlock_nxt = 1'b0;
            w_alarm_nxt  = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_entry     <= '0;
         r_code      <= DEFAULT_CODE;
         r_digit_cnt <= '0;
         r_fail_cnt  <= '0;
         r_timer     <= '0;
         r_unlock    <= 1'b0;
         r_alarm     <= 1'b0;
      end else begin
         r_entry     <= w_entry_nxt;
         r_code      <= w_code_nxt;
         r_digit_cnt <= w_digit_nxt;
         r_fail_cnt  <= w_fail_nxt;
         r_timer     <= w_timer_nxt;
         r_unlock    <= w_unlock_nxt;
         r_alarm     <= w_alarm_nxt;
      end
   end

   assign unlock    = r_unlock;
   assign alarm     = r_alarm;
   assign fail_cnt  = r_fail_cnt;
   assign digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_code_lock_param.sv
// ----------------------------------------------------------------------------
// tb_code_lock_param
// Directed bench for code_lock_param. Two instances: the default 5-digit
// configuration and an 8-digit, single-failure configuration. Expected
// output snapshots are queued as stimulus is driven and popped once the
// corresponding clock edge has produced the DUT response.
// ----------------------------------------------------------------------------
module tb_code_lock_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       b0, b1, prog_en;
   logic [4:0] prog_code;
   logic       unlock, alarm;
   logic [1:0] fail_cnt;
   logic [2:0] digit_cnt;

   logic       c0, c1, prog_en2;
   logic [7:0] prog_code2;
   logic       unlock2, alarm2;
   logic [0:0] fail_cnt2;
   logic [3:0] digit_cnt2;

   always #5 clk = ~clk;

   code_lock_param dut (
      .clk       (clk),
      .reset     (reset),
      .b0        (b0),
      .b1        (b1),
      .prog_en   (prog_en),
      .prog_code (prog_code),
      .unlock    (unlock),
      .alarm     (alarm),
      .fail_cnt  (fail_cnt),
      .digit_cnt (digit_cnt)
   );

   code_lock_param #(
      .CODE_LEN     (8),
      .DEFAULT_CODE (8'hA5),
      .MAX_FAIL     (1),
      .UNLOCK_CYC   (4),
      .LOCKOUT_CYC  (16)
   ) dut2 (
      .clk       (clk),
      .reset     (reset),
      .b0        (c0),
      .b1        (c1),
      .prog_en   (prog_en2),
      .prog_code (prog_code2),
      .unlock    (unlock2),
      .alarm     (alarm2),
      .fail_cnt  (fail_cnt2),
      .digit_cnt (digit_cnt2)
   );

   typedef struct {
      int    inst;
      string tag;
      int    u;
      int    a;
      int    f;
      int    d;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
   endtask

   task automatic exp_push(input int inst, input string tag,
                           input int u, input int a, input int f, input int d);
      exp_t e;
      e.inst = inst; e.tag = tag; e.u = u; e.a = a; e.f = f; e.d = d;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_total++;
         $error("FAIL sb_empty: observed 0 entries required 1");
      end else begin
         e = sb_q.pop_front();
         if (e.inst == 1) begin
            chk({e.tag, "/unlock"},    32'(unlock),    e.u);
            chk({e.tag, "/alarm"},     32'(alarm),     e.a);
            chk({e.tag, "/fail_cnt"},  32'(fail_cnt),  e.f);
            chk({e.tag, "/digit_cnt"}, 32'(digit_cnt), e.d);
         end else begin
            chk({e.tag, "/unlock"},    32'(unlock2),    e.u);
            chk({e.tag, "/alarm"},     32'(alarm2),     e.a);
            chk({e.tag, "/fail_cnt"},  32'(fail_cnt2),  e.f);
            chk({e.tag, "/digit_cnt"}, 32'(digit_cnt2), e.d);
         end
      end
   endtask

   task automatic press1(input logic dig);
      b0 = ~dig;
      b1 = dig;
      tick();
      b0 = 1'b0;
      b1 = 1'b0;
   endtask

   task automatic press2(input logic dig);
      c0 = ~dig;
      c1 = dig;
      tick();
      c0 = 1'b0;
      c1 = 1'b0;
   endtask

   // Full 5-digit attempt on dut; expectation applies after the last digit
   task automatic enter1(input logic [4:0] code, input string tag,
                         input int u, input int a, input int f);
      for (int i = 4; i >= 0; i--) begin
         if (i == 0) exp_push(1, tag, u, a, f, 0);
         press1(code[i]);
      end
      sb_check();
   endtask

   task automatic enter2(input logic [7:0] code, input string tag,
                         input int u, input int a, input int f);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0) exp_push(2, tag, u, a, f, 0);
         press2(code[i]);
      end
      sb_check();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] cd;
      cd         = 5'b01011;
      reset      = 1'b1;
      b0         = 1'b0;
      b1         = 1'b0;
      prog_en    = 1'b0;
      prog_code  = 5'b00000;
      c0         = 1'b0;
      c1         = 1'b0;
      prog_en2   = 1'b0;
      prog_code2 = 8'h00;

      tick();
      tick();
      exp_push(1, "reset_state", 0, 0, 0, 0);
      sb_check();
      exp_push(2, "reset_state2", 0, 0, 0, 0);
      sb_check();

      // Default code; first digit lands on the first edge after release
      reset = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         if (i == 0) exp_push(1, "default_unlock", 1, 0, 0, 0);
         else        exp_push(1, "digit_cnt_inc", 0, 0, 0, 5 - i);
         press1(cd[i]);
         sb_check();
      end
      // Unlock lasts exactly 4 cycles; digits pressed meanwhile are ignored
      for (int k = 1; k <= 3; k++) begin
         exp_push(1, "unlock_hold", 1, 0, 0, 0);
         press1(1'(k % 2));
         sb_check();
      end
      exp_push(1, "unlock_end", 0, 0, 0, 0);
      press1(1'b1);
      sb_check();

      // Three wrong codes -> lockout
      enter1(5'b11111, "wrong1", 0, 0, 1);
      enter1(5'b11111, "wrong2", 0, 0, 2);
      enter1(5'b11111, "lockout_entry", 0, 1, 3);
      prog_en   = 1'b1;
      prog_code = 5'b11111;
      for (int k = 1; k <= 15; k++) begin
         exp_push(1, "lockout_hold", 0, 1, 3, 0);
         press1(1'(k % 2));
         sb_check();
      end
      prog_en = 1'b0;
      exp_push(1, "lockout_end", 0, 0, 0, 0);
      tick();
      sb_check();

      // Partial entry, clear (with prog_en in ENTRY), then the correct code
      press1(1'b0);
      press1(1'b1);
      exp_push(1, "partial_entry", 0, 0, 0, 3);
      press1(1'b0);
      sb_check();
      b0        = 1'b1;
      b1        = 1'b1;
      prog_en   = 1'b1;
      prog_code = 5'b11111;
      exp_push(1, "clear", 0, 0, 0, 0);
      tick();
      b0      = 1'b0;
      b1      = 1'b0;
      prog_en = 1'b0;
      sb_check();
      enter1(5'b01011, "unlock_after_clear", 1, 0, 0);

      // Program a new code in UNLOCK; unlock must not be extended
      prog_en   = 1'b1;
      prog_code = 5'b10100;
      exp_push(1, "prog_hold", 1, 0, 0, 0);
      tick();
      prog_en = 1'b0;
      sb_check();
      exp_push(1, "prog_hold", 1, 0, 0, 0);
      tick();
      sb_check();
      exp_push(1, "prog_hold", 1, 0, 0, 0);
      tick();
      sb_check();
      exp_push(1, "prog_no_extend", 0, 0, 0, 0);
      tick();
      sb_check();
      enter1(5'b01011, "old_code_fails", 0, 0, 1);
      enter1(5'b10100, "new_code_unlocks", 1, 0, 0);

      // Asynchronous reset mid-UNLOCK, away from any clock edge
      #2;
      reset = 1'b1;
      #1;
      exp_push(1, "async_reset", 0, 0, 0, 0);
      sb_check();
      tick();
      reset = 1'b0;
      enter1(5'b10100, "prog_discarded", 0, 0, 1);
      enter1(5'b01011, "default_restored", 1, 0, 0);
      repeat (4) tick();
      exp_push(1, "idle", 0, 0, 0, 0);
      sb_check();

      // 8-digit instance: single failure locks out, default A5 unlocks
      enter2(8'h00, "len8_lockout", 0, 1, 1);
      for (int k = 1; k <= 15; k++) begin
         exp_push(2, "len8_lockout_hold", 0, 1, 1, 0);
         press2(1'(k % 2));
         sb_check();
      end
      exp_push(2, "len8_lockout_end", 0, 0, 0, 0);
      tick();
      sb_check();
      enter2(8'hA5, "len8_unlock", 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
